// File: rtl/i2c_arb_pkg.sv
// Shared types and default widths for the I2C register arbiter.
package i2c_arb_pkg;

  localparam int ARB_ADDR_W = 8;
  localparam int ARB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_I2C_WR = 2'd0,
    SRC_I2C_PF = 2'd1,
    SRC_HOST   = 2'd2
  } arb_src_e;

endpackage

// File: rtl/i2c_reg_arbiter_if.sv
// Bus bundle between the arbiter, the I2C slave, the host port and the register RAM.
// slave modport = arbiter side, master modport = surrounding logic / bench side.
interface i2c_reg_arbiter_if
  import i2c_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_W,
  parameter int DATA_WIDTH = ARB_DATA_W
) ();

  logic                  i2c_we;
  logic [ADDR_WIDTH-1:0] i2c_addr;
  logic [DATA_WIDTH-1:0] i2c_wdata;
  logic [DATA_WIDTH-1:0] i2c_rdata;
  logic                  i2c_rvalid;
  logic                  i2c_busy;
  logic                  i2c_ovf;

  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_gnt;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  host_rvalid;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  i2c_we, i2c_addr, i2c_wdata, i2c_busy,
    output i2c_rdata, i2c_rvalid, i2c_ovf,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output i2c_we, i2c_addr, i2c_wdata, i2c_busy,
    input  i2c_rdata, i2c_rvalid, i2c_ovf,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/i2c_arb_wrbuf.sv
// Single-entry holding buffer for I2C write pulses. A pulse arriving while the
// entry is still occupied (and not being drained this cycle) is dropped and
// recorded in the sticky overflow flag.
module i2c_arb_wrbuf #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i2c_we,
  input  logic [ADDR_WIDTH-1:0] i2c_addr,
  input  logic [DATA_WIDTH-1:0] i2c_wdata,
  input  logic                  wr_done,
  output logic                  wr_pend,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ovf
);

  // capture / drain the entry; a drain in the same cycle frees room for a new pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      ovf     <= 1'b0;
    end else begin
      if (wr_done) wr_pend <= 1'b0;
      if (i2c_we) begin
        if (wr_pend && !wr_done) begin
          ovf <= 1'b1;
        end else begin
          wr_pend <= 1'b1;
          wr_addr <= i2c_addr;
          wr_data <= i2c_wdata;
        end
      end
    end
  end

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Arbitrates one single-port register RAM between I2C slave writes, the I2C
// read prefetch and a host port. Optional macro I2C_HOST_LOCK_EN holds off
// host grants while the I2C slave reports a transaction in progress.
//
// state   | meaning
// IDLE    | pick next source: I2C write > I2C prefetch > host
// ISSUE   | mem strobe on the bus for one cycle (host_gnt pulses here for host)
// RD_WAIT | RAM read data valid, captured into i2c_rdata or host_rdata
module i2c_reg_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_W,
  parameter int DATA_WIDTH = ARB_DATA_W
) (
  input logic               clk,
  input logic               reset_n,
  i2c_reg_arbiter_if.slave  bus
);

  arb_state_e            state_q, state_d;
  arb_src_e              src_q, src_d;
  logic                  launch;
  logic                  nxt_we;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [DATA_WIDTH-1:0] nxt_wdata;

  logic                  mem_en_q, mem_we_q, host_gnt_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic                  wr_pend, wr_done, ovf;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  host_req_q, host_lock, host_ok;
  logic                  pf_pend, wr_hit;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] i2c_rdata_q, host_rdata_q;
  logic                  i2c_rvalid_q, host_rvalid_q;

`ifdef I2C_HOST_LOCK_EN
  assign host_lock = bus.i2c_busy;
`else
  assign host_lock = 1'b0;
`endif

  // host request is staged one cycle so it is qualified the same way as I2C work
  assign host_ok = host_req_q && !host_lock;
  assign wr_done = (state_q == ISSUE) && (src_q == SRC_I2C_WR);
  assign wr_hit  = (state_q == ISSUE) && mem_we_q && (mem_addr_q == bus.i2c_addr);

  i2c_arb_wrbuf #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wrbuf (
    .clk       (clk),
    .reset_n   (reset_n),
    .i2c_we    (bus.i2c_we),
    .i2c_addr  (bus.i2c_addr),
    .i2c_wdata (bus.i2c_wdata),
    .wr_done   (wr_done),
    .wr_pend   (wr_pend),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ovf       (ovf)
  );

  // next state, source select and the memory command to launch
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    launch    = 1'b0;
    nxt_we    = 1'b0;
    nxt_addr  = bus.i2c_addr;
    nxt_wdata = '0;
    case (state_q)
      IDLE: begin
        if (wr_pend) begin
          src_d  = SRC_I2C_WR;
          launch = 1'b1;
        end else if (pf_pend) begin
          src_d  = SRC_I2C_PF;
          launch = 1'b1;
        end else if (host_ok) begin
          src_d  = SRC_HOST;
          launch = 1'b1;
        end
        if (launch) state_d = ISSUE;
      end
      ISSUE:   state_d = mem_we_q ? IDLE : RD_WAIT;
      RD_WAIT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    case (src_d)
      SRC_I2C_WR: begin
        nxt_we    = 1'b1;
        nxt_addr  = wr_addr;
        nxt_wdata = wr_data;
      end
      SRC_HOST: begin
        nxt_we    = bus.host_we;
        nxt_addr  = bus.host_addr;
        nxt_wdata = bus.host_wdata;
      end
      default: begin
        nxt_we    = 1'b0;
        nxt_addr  = bus.i2c_addr;
        nxt_wdata = '0;
      end
    endcase
  end

  // state register and one-cycle memory strobe; mem_addr holds so RD_WAIT knows what was fetched
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      src_q       <= SRC_I2C_WR;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      host_gnt_q  <= 1'b0;
      host_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      mem_en_q   <= launch;
      mem_we_q   <= launch && nxt_we;
      host_gnt_q <= launch && (src_d == SRC_HOST);
      host_req_q <= bus.host_req && !(launch && (src_d == SRC_HOST)) && !host_gnt_q && !host_lock;
      if (launch) begin
        mem_addr_q  <= nxt_addr;
        mem_wdata_q <= nxt_wdata;
      end
    end
  end

  // read data capture and prefetch validity tracking
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pf_pend       <= 1'b1;
      last_addr     <= '0;
      i2c_rdata_q   <= '0;
      i2c_rvalid_q  <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      host_rvalid_q <= 1'b0;
      if (state_q == RD_WAIT && src_q == SRC_HOST) begin
        host_rdata_q  <= bus.mem_rdata;
        host_rvalid_q <= 1'b1;
      end
      if (state_q == RD_WAIT && src_q == SRC_I2C_PF) begin
        i2c_rdata_q <= bus.mem_rdata;
        last_addr   <= mem_addr_q;
        // the slave may have moved on while the fetch was in flight
        if (bus.i2c_addr == mem_addr_q) begin
          i2c_rvalid_q <= 1'b1;
          pf_pend      <= 1'b0;
        end else begin
          i2c_rvalid_q <= 1'b0;
          pf_pend      <= 1'b1;
        end
      end else if (bus.i2c_addr != last_addr || wr_hit) begin
        i2c_rvalid_q <= 1'b0;
        pf_pend      <= 1'b1;
      end
    end
  end

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.host_gnt    = host_gnt_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.i2c_rdata   = i2c_rdata_q;
  assign bus.i2c_rvalid  = i2c_rvalid_q;
  assign bus.i2c_ovf     = ovf;

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Directed bench for i2c_reg_arbiter with a 1-cycle-latency RAM model.
module tb_i2c_reg_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  logic [15:0] mem [256];
  logic [15:0] mem_rd_q;

  always #5 clk = ~clk;

  i2c_reg_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  i2c_reg_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      mem_rd_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = mem_rd_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_i2c_rvalid(input string tag);
    int n;
    n = 0;
    while (!bus.i2c_rvalid && n < 4) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, bus.i2c_rvalid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    bus.i2c_we     = 1'b0;
    bus.i2c_addr   = 8'h00;
    bus.i2c_wdata  = 16'h0000;
    bus.i2c_busy   = 1'b0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = 8'h00;
    bus.host_wdata = 16'h0000;
    mem_rd_q       = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    #1;
    mem[8'h00] <= 16'h1234;
    mem[8'h03] <= 16'h0303;
    mem[8'h0A] <= 16'h1111;

    // reset values
    ticks(3);
    chk("rst_i2c_rvalid",  {31'd0, bus.i2c_rvalid},  32'd0);
    chk("rst_ovf",         {31'd0, bus.i2c_ovf},     32'd0);
    chk("rst_host_gnt",    {31'd0, bus.host_gnt},    32'd0);
    chk("rst_host_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
    chk("rst_mem_en",      {31'd0, bus.mem_en},      32'd0);
    chk("rst_mem_we",      {31'd0, bus.mem_we},      32'd0);
    chk("rst_mem_addr",    {24'd0, bus.mem_addr},    32'd0);
    chk("rst_i2c_rdata",   {16'd0, bus.i2c_rdata},   32'd0);

    // release: prefetch of address 0x00
    reset_n = 1'b1;
    wait_i2c_rvalid("pf0_rvalid");
    chk("pf0_rdata", {16'd0, bus.i2c_rdata}, 32'h1234);

    // simultaneous I2C write and host read to 0x05
    bus.i2c_addr = 8'h05;
    ticks(6);
    chk("pf5_rvalid", {31'd0, bus.i2c_rvalid}, 32'd1);
    chk("pf5_rdata",  {16'd0, bus.i2c_rdata},  32'h0000);
    bus.i2c_we    = 1'b1;
    bus.i2c_wdata = 16'hBEEF;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 8'h05;
    tick();
    bus.i2c_we = 1'b0;
    tick();
    chk("sim_wr_en",    {31'd0, bus.mem_en},    32'd1);
    chk("sim_wr_we",    {31'd0, bus.mem_we},    32'd1);
    chk("sim_wr_addr",  {24'd0, bus.mem_addr},  32'h05);
    chk("sim_wr_data",  {16'd0, bus.mem_wdata}, 32'hBEEF);
    chk("sim_wr_nognt", {31'd0, bus.host_gnt},  32'd0);
    tick();
    chk("sim_rvalid_drop", {31'd0, bus.i2c_rvalid}, 32'd0);
    tick();
    chk("sim_pf_en",    {31'd0, bus.mem_en},   32'd1);
    chk("sim_pf_we",    {31'd0, bus.mem_we},   32'd0);
    chk("sim_pf_nognt", {31'd0, bus.host_gnt}, 32'd0);
    ticks(2);
    chk("sim_pf_rvalid", {31'd0, bus.i2c_rvalid}, 32'd1);
    chk("sim_pf_rdata",  {16'd0, bus.i2c_rdata},  32'hBEEF);
    tick();
    chk("sim_host_gnt",  {31'd0, bus.host_gnt}, 32'd1);
    chk("sim_host_addr", {24'd0, bus.mem_addr}, 32'h05);
    bus.host_req = 1'b0;
    ticks(2);
    chk("sim_host_rvalid", {31'd0, bus.host_rvalid}, 32'd1);
    chk("sim_host_rdata",  {16'd0, bus.host_rdata},  32'hBEEF);
    tick();
    chk("sim_host_rvalid_pulse", {31'd0, bus.host_rvalid}, 32'd0);

    // host write to the address the slave is looking at
    bus.i2c_addr = 8'h0A;
    ticks(6);
    chk("pfA_rvalid", {31'd0, bus.i2c_rvalid}, 32'd1);
    chk("pfA_rdata",  {16'd0, bus.i2c_rdata},  32'h1111);
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_addr  = 8'h0A;
    bus.host_wdata = 16'h5555;
    ticks(2);
    chk("hw_gnt",   {31'd0, bus.host_gnt},  32'd1);
    chk("hw_we",    {31'd0, bus.mem_we},    32'd1);
    chk("hw_wdata", {16'd0, bus.mem_wdata}, 32'h5555);
    bus.host_req = 1'b0;
    tick();
    chk("hw_rvalid_drop", {31'd0, bus.i2c_rvalid}, 32'd0);
    ticks(3);
    chk("hw_repf_rvalid", {31'd0, bus.i2c_rvalid}, 32'd1);
    chk("hw_repf_rdata",  {16'd0, bus.i2c_rdata},  32'h5555);

    // two I2C write pulses while a host read is in flight
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 8'h03;
    ticks(2);
    chk("ovf_host_gnt", {31'd0, bus.host_gnt}, 32'd1);
    bus.host_req  = 1'b0;
    bus.i2c_we    = 1'b1;
    bus.i2c_wdata = 16'hAAAA;
    tick();
    bus.i2c_we = 1'b0;
    tick();
    chk("ovf_host_rvalid", {31'd0, bus.host_rvalid}, 32'd1);
    chk("ovf_host_rdata",  {16'd0, bus.host_rdata},  32'h0303);
    bus.i2c_we    = 1'b1;
    bus.i2c_wdata = 16'hBBBB;
    tick();
    bus.i2c_we = 1'b0;
    chk("ovf_wr_en",   {31'd0, bus.mem_en},    32'd1);
    chk("ovf_wr_data", {16'd0, bus.mem_wdata}, 32'hAAAA);
    chk("ovf_flag",    {31'd0, bus.i2c_ovf},   32'd1);
    tick();
    chk("ovf_no_second_wr", {31'd0, bus.mem_en}, 32'd0);
    ticks(3);
    chk("ovf_pf_rvalid", {31'd0, bus.i2c_rvalid}, 32'd1);
    chk("ovf_pf_rdata",  {16'd0, bus.i2c_rdata},  32'hAAAA);
    ticks(5);
    chk("ovf_sticky", {31'd0, bus.i2c_ovf}, 32'd1);

    // host request while the slave is busy
    bus.i2c_busy  = 1'b1;
    bus.host_req  = 1'b1;
    bus.host_we   = 1'b0;
    bus.host_addr = 8'h03;
`ifdef I2C_HOST_LOCK_EN
    ticks(5);
    chk("lock_no_gnt",    {31'd0, bus.host_gnt}, 32'd0);
    chk("lock_no_mem_en", {31'd0, bus.mem_en},   32'd0);
    bus.i2c_busy = 1'b0;
    tick();
    chk("lock_gnt_early", {31'd0, bus.host_gnt}, 32'd0);
    tick();
    chk("lock_gnt", {31'd0, bus.host_gnt}, 32'd1);
`else
    ticks(2);
    chk("busy_gnt", {31'd0, bus.host_gnt}, 32'd1);
`endif
    bus.host_req = 1'b0;
    ticks(2);
    chk("busy_rvalid", {31'd0, bus.host_rvalid}, 32'd1);
    chk("busy_rdata",  {16'd0, bus.host_rdata},  32'h0303);
    bus.i2c_busy = 1'b0;
    ticks(2);

    // reset during RD_WAIT of a host read
    bus.host_req  = 1'b1;
    bus.host_addr = 8'h03;
    ticks(2);
    chk("mrst_gnt", {31'd0, bus.host_gnt}, 32'd1);
    bus.host_req = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    chk("mrst_host_rvalid", {31'd0, bus.host_rvalid}, 32'd0);
    chk("mrst_host_rdata",  {16'd0, bus.host_rdata},  32'd0);
    chk("mrst_i2c_rvalid",  {31'd0, bus.i2c_rvalid},  32'd0);
    chk("mrst_i2c_rdata",   {16'd0, bus.i2c_rdata},   32'd0);
    chk("mrst_ovf",         {31'd0, bus.i2c_ovf},     32'd0);
    chk("mrst_mem_en",      {31'd0, bus.mem_en},      32'd0);
    chk("mrst_mem_addr",    {24'd0, bus.mem_addr},    32'd0);
    chk("mrst_gnt_low",     {31'd0, bus.host_gnt},    32'd0);
    reset_n = 1'b1;
    wait_i2c_rvalid("mrst_pf_rvalid");
    chk("mrst_pf_rdata",    {16'd0, bus.i2c_rdata},   32'hAAAA);
    chk("mrst_no_rvalid",   {31'd0, bus.host_rvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
